decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I/RV64I instruction decode stage with a valid/ready handshake and a 2-entry skid.
//  Sits between fetch and register-read. Splits out register indices, funct fields and the
//  sign-extended immediate, plus format one-hot, operand-use flags and an illegal-instruction flag.
//  Adds flush support and XLEN generalisation. Unknown encodings produce defined outputs, not X.
// PARAMETERS
//  XLEN      32  datapath width, 32 or 64; 64 enables OP-IMM-32/OP-32 and XLEN-wide imm/pc
//  SKID_EN   1   1 = 2-entry buffering, in_ready registered; 0 = single reg, in_ready = !out_valid|out_ready
// PORTS
//  clk         in   1     clock; all state updates on posedge
//  rst         in   1     synchronous, active-high reset
//  flush       in   1     discard all buffered instructions
//  in_valid    in   1     fetch offers instruction
//  in_ready    out  1     stage can accept this cycle
//  in_inst     in   32    raw instruction word
//  in_pc       in   XLEN  instruction address
//  out_valid   out  1     decoded instruction available
//  out_ready   in   1     consumer takes it this cycle
//  out_pc      out  XLEN  passed-through pc
//  out_opcode  out  5     inst[6:2]
//  out_rd/out_rs1/out_rs2  out 5 each  inst[11:7]/[19:15]/[24:20]
//  out_func3   out  3     inst[14:12]
//  out_funct7  out  7     inst[31:25]
//  out_imm     out  XLEN  sign-extended immediate per format, 0 for R/invalid
//  out_fmt     out  6     one-hot {J,U,B,S,I,R}; 0 when invalid
//  out_use_rs1/out_use_rs2/out_we_rd  out 1 each  operand read / rd write flags (we_rd=0 when rd==0)
//  out_invalid out  1     illegal encoding
// BEHAVIOUR
//  Reset: out_valid=0, skid empty, in_ready=1 the cycle after rst deasserts; all out_* data = 0.
//  Latency: 1 cycle from accept (in_valid&in_ready) to out_valid. Throughput 1 per cycle with out_ready=1.
//  Transfer rules: input accepted iff in_valid&in_ready. Output consumed iff out_valid&out_ready.
//   While out_valid=1 and out_ready=0, out_* are held stable.
//  Skid (SKID_EN=1) holds two entries: output reg (OUT) and skid reg (SK).
//   - Accept with OUT free or OUT consumed -> data goes to OUT.
//   - Accept while OUT stalled -> data goes to SK; in_ready=0 next cycle.
//   - OUT consumed and SK full -> SK moves to OUT, in_ready=1 next cycle.
//   - in_ready depends only on registers: in_ready = !SK_full.
//  Decoding happens before registering; OUT and SK store decoded fields, not raw inst.
//  Order is strictly FIFO.
//  Flush: OUT and SK both invalid next cycle. Overrides a same-cycle accept (that instruction is dropped).
//   in_ready=1 next cycle.
//  Reset mid-stream behaves as flush; all data is cleared.
//  Formats by opcode:
//   R: OP 01100, (XLEN64) OP-32 01110
//   I: LOAD 00000, OP-IMM 00100, JALR 11001, SYSTEM 11100, MISC-MEM 00011, (XLEN64) OP-IMM-32 00110
//   S: STORE 01000
//   B: BRANCH 11000
//   U: LUI 01101, AUIPC 00101
//   J: JAL 11011
//  Immediate encodings, sign-extended from inst[31] to XLEN:
//   I  = inst[31:20]
//   S  = {inst[31:25],inst[11:7]}
//   B  = {inst[31],inst[7],inst[30:25],inst[11:8],0}
//   U  = {inst[31:12],12'b0}
//   J  = {inst[31],inst[19:12],inst[20],inst[30:21],0}  (exactly 21 significant bits)
//  invalid=1 if inst[1:0]!=11, opcode not listed, or OP/OP-32 funct7 not in {0000000,0100000,0000001}.
//   When invalid: fmt=0, imm=0, use_rs1/use_rs2/we_rd=0. pc and raw fields still pass through.
//  Operand-use flags:
//   use_rs1=1 for R,I,S,B except SYSTEM with func3[2]=1 or func3=000
//   use_rs2=1 for R,S,B
//   we_rd=1 for R,I,U,J with rd!=0, except MISC-MEM and SYSTEM func3=000
// STRUCTURE
//  rv_decode_pkg: opcode localparams, fmt one-hot enum, decoded_t packed struct (all out_* fields + pc).
//  rv_decode_comb: purely combinational inst+pc -> decoded_t, parametrised by XLEN.
//  decode_stage instantiates it once on the input side; holds OUT/SK as decoded_t registers.
// TESTING
//  1 addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, fmt=I, rd=1, rs1=2,
//    imm=0xFFFFFFFF, we_rd=1, use_rs2=0.
//  2 jal x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC, fmt=J. Same test with XLEN=64 -> imm=0xFFFF_FFFF_FFFF_FFFC.
//  3 Backpressure: out_ready=0, stream 3 insts -> first 2 accepted, in_ready=0 from cycle 3.
//    Raise out_ready -> all 3 emerge in order, no duplicates or drops.
//  4 Flush with both entries full and in_valid=1 in the same cycle -> out_valid=0 next cycle,
//    in_ready=1, the flushed-cycle instruction never appears.
//  5 0x00000000 and 0x0000007F -> invalid=1, fmt=0, imm=0, we_rd=0. 0x40000033 (sub) -> valid R.
//    0x80000033 -> invalid.
//  6 rst asserted mid-stream with out_valid=1 -> next cycle out_valid=0, all out_* data=0, in_ready=1.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, format one-hot and the decoded record.
package rv_decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [5:0] {
    FMT_NONE = 6'b000000,
    FMT_R    = 6'b000001,
    FMT_I    = 6'b000010,
    FMT_S    = 6'b000100,
    FMT_B    = 6'b001000,
    FMT_U    = 6'b010000,
    FMT_J    = 6'b100000
  } fmt_e;

  // pc/imm are held at full 64-bit width; narrower stages use the low XLEN bits
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          func3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic                use_rs1;
    logic                use_rs2;
    logic                we_rd;
    logic                invalid;
  } decoded_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational instruction decoder: raw word + pc -> decoded_t.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  localparam bit RV64 = (XLEN == 64);

  fmt_e       fmt;
  logic [4:0] opc;
  logic [2:0] f3;
  logic       f7_ok;
  logic       is_sys;

  assign opc    = inst[6:2];
  assign f3     = inst[14:12];
  assign f7_ok  = (inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000) ||
                  (inst[31:25] == 7'b0000001);
  assign is_sys = (opc == OPC_SYSTEM);

  always_comb begin
    fmt = FMT_NONE;
    case (opc)
      OPC_OP:       fmt = f7_ok ? FMT_R : FMT_NONE;
      OPC_OP32:     fmt = (RV64 && f7_ok) ? FMT_R : FMT_NONE;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                    fmt = FMT_I;
      OPC_OP_IMM32: fmt = RV64 ? FMT_I : FMT_NONE;
      OPC_STORE:    fmt = FMT_S;
      OPC_BRANCH:   fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:
                    fmt = FMT_U;
      OPC_JAL:      fmt = FMT_J;
      default:      fmt = FMT_NONE;
    endcase
    if (inst[1:0] != 2'b11) fmt = FMT_NONE;
  end

  always_comb begin
    dec         = '0;
    dec.pc      = XLEN_MAX'(pc);
    dec.opcode  = opc;
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.func3   = f3;
    dec.funct7  = inst[31:25];
    dec.fmt     = fmt;
    dec.invalid = (fmt == FMT_NONE);
    case (fmt)
      FMT_I:   dec.imm = {{52{inst[31]}}, inst[31:20]};
      FMT_S:   dec.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   dec.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   dec.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      FMT_J:   dec.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: dec.imm = '0;
    endcase
    // CSR-immediate forms and ECALL/EBREAK do not read rs1
    dec.use_rs1 = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B)) &&
                  !(is_sys && (f3[2] || (f3 == 3'b000)));
    dec.use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    dec.we_rd   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J)) &&
                  (inst[11:7] != 5'd0) && (opc != OPC_MISC_MEM) &&
                  !(is_sys && (f3 == 3'b000));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake with an optional 2-entry skid (OUT + SK).
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_fmt,
  output logic            out_use_rs1,
  output logic            out_use_rs2,
  output logic            out_we_rd,
  output logic            out_invalid
);

  decoded_t in_dec;
  decoded_t out_q, out_d, sk_q, sk_d;
  logic     out_vld_q, out_vld_d, sk_vld_q, sk_vld_d;
  logic     accept, out_free;

  rv_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .pc   (in_pc),
    .dec  (in_dec)
  );

  // With the skid, in_ready is a pure register output; without it, it follows out_ready
  assign in_ready = SKID_EN ? !sk_vld_q : (!out_vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_vld_q || out_ready;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sk_d      = sk_q;
    sk_vld_d  = sk_vld_q;
    if (out_free) begin
      if (sk_vld_q) begin
        out_d     = sk_q;
        out_vld_d = 1'b1;
        sk_vld_d  = 1'b0;
      end else begin
        out_d     = accept ? in_dec : out_q;
        out_vld_d = accept;
      end
    end else if (accept) begin
      sk_d     = in_dec;
      sk_vld_d = 1'b1;
    end
    if (flush) begin
      out_vld_d = 1'b0;
      sk_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      sk_q      <= '0;
      out_vld_q <= 1'b0;
      sk_vld_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      sk_q      <= sk_d;
      out_vld_q <= out_vld_d;
      sk_vld_q  <= sk_vld_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_pc      = out_q.pc[XLEN-1:0];
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_func3   = out_q.func3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_use_rs1 = out_q.use_rs1;
  assign out_use_rs2 = out_q.use_rs2;
  assign out_we_rd   = out_q.we_rd;
  assign out_invalid = out_q.invalid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic against a queue-based reference.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [4:0]  out_opcode, out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3;
  logic [6:0]  out_funct7;
  logic [5:0]  out_fmt;
  logic        out_use_rs1, out_use_rs2, out_we_rd, out_invalid;

  logic        flush64, in_valid64, in_ready64, out_ready64, out_valid64;
  logic [31:0] in_inst64;
  logic [63:0] in_pc64, out_pc64, out_imm64;
  logic [4:0]  out_opcode64, out_rd64, out_rs164, out_rs264;
  logic [2:0]  out_func364;
  logic [6:0]  out_funct764;
  logic [5:0]  out_fmt64;
  logic        out_use_rs164, out_use_rs264, out_we_rd64, out_invalid64;

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_func3(out_func3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
    .out_we_rd(out_we_rd), .out_invalid(out_invalid)
  );

  decode_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_inst(in_inst64), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_pc(out_pc64), .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs164),
    .out_rs2(out_rs264), .out_func3(out_func364), .out_funct7(out_funct764),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_use_rs1(out_use_rs164),
    .out_use_rs2(out_use_rs264), .out_we_rd(out_we_rd64), .out_invalid(out_invalid64)
  );

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  opc, rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [5:0]  fmt;
    logic        u1, u2, we, inv;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: format class number 1..6 = R,I,S,B,U,J; 0 = illegal
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit rv64);
    exp_t   e;
    int     kind;
    longint imm;
    bit     sys;
    e.pc = pc; e.opc = inst[6:2]; e.rd = inst[11:7]; e.rs1 = inst[19:15];
    e.rs2 = inst[24:20]; e.f3 = inst[14:12]; e.f7 = inst[31:25];
    case (int'(inst[6:2]))
      12:              kind = 1;
      14:              kind = rv64 ? 1 : 0;
      0, 3, 4, 25, 28: kind = 2;
      6:               kind = rv64 ? 2 : 0;
      8:               kind = 3;
      24:              kind = 4;
      5, 13:           kind = 5;
      27:              kind = 6;
      default:         kind = 0;
    endcase
    if (inst[1:0] != 2'b11) kind = 0;
    if (kind == 1 && !(inst[31:25] inside {7'h00, 7'h20, 7'h01})) kind = 0;
    case (kind)
      2:       imm = longint'($signed(inst[31:20]));
      3:       imm = longint'($signed({inst[31:25], inst[11:7]}));
      4:       imm = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      5:       imm = longint'($signed({inst[31:12], 12'h000}));
      6:       imm = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = 0;
    endcase
    sys   = (inst[6:2] == 5'd28);
    e.imm = imm;
    e.fmt = (kind == 0) ? 6'd0 : 6'(1 << (kind - 1));
    e.inv = (kind == 0);
    e.u1  = (kind inside {1, 2, 3, 4}) && !(sys && (inst[14] || inst[14:12] == 3'd0));
    e.u2  = (kind inside {1, 3, 4});
    e.we  = (kind inside {1, 2, 5, 6}) && (inst[11:7] != 0) && (inst[6:2] != 5'd3) &&
            !(sys && inst[14:12] == 3'd0);
    return e;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("pc", {32'd0, out_pc}, {32'd0, e.pc[31:0]});
    chk("opcode", out_opcode, e.opc);
    chk("rd", out_rd, e.rd);
    chk("rs1", out_rs1, e.rs1);
    chk("rs2", out_rs2, e.rs2);
    chk("func3", out_func3, e.f3);
    chk("funct7", out_funct7, e.f7);
    chk("imm", {32'd0, out_imm}, {32'd0, e.imm[31:0]});
    chk("fmt", out_fmt, e.fmt);
    chk("use_rs1", out_use_rs1, e.u1);
    chk("use_rs2", out_use_rs2, e.u2);
    chk("we_rd", out_we_rd, e.we);
    chk("invalid", out_invalid, e.inv);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_data"}, {out_pc, out_imm}, 64'd0);
    chk({tag, "_fields"}, {out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_funct7,
        out_fmt, out_use_rs1, out_use_rs2, out_we_rd, out_invalid}, 64'd0);
  endtask

  // One cycle: drive at negedge, check registered outputs, advance the reference queue
  task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc;
    @(negedge clk);
    in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) cmp_out(q[0]);
    acc = iv && (q.size() < 2);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(model(inst, {32'd0, pc}, 1'b0));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    check_zero(tag);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[6:0] = 7'b0000011;  1: r[6:0] = 7'b0001111;  2: r[6:0] = 7'b0010011;
      3: r[6:0] = 7'b0010111;  4: r[6:0] = 7'b0100011;  5: r[6:0] = 7'b0110011;
      6: r[6:0] = 7'b0110111;  7: r[6:0] = 7'b1100011;  8: r[6:0] = 7'b1100111;
      9: r[6:0] = 7'b1101111; 10: r[6:0] = 7'b1110011; 11: r[6:0] = 7'b0111011;
      default: ;
    endcase
    if (r[6:0] == 7'b0110011 && $urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0:       r[31:25] = 7'h00;
        1:       r[31:25] = 7'h20;
        default: r[31:25] = 7'h01;
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [31:0] pc;
    exp_t        e64;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    flush64 = 1'b0; in_valid64 = 1'b0; in_inst64 = '0; in_pc64 = '0; out_ready64 = 1'b0;
    do_reset("reset");

    // addi x1,x2,-1
    step(1'b1, 32'hFFF10093, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_imm", out_imm, 32'hFFFFFFFF);
    chk("t1_fmt", out_fmt, 6'b000010);
    chk("t1_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd2});
    chk("t1_flags", {out_we_rd, out_use_rs2}, 2'b10);

    // jal x1,-4
    step(1'b1, 32'hFFDFF0EF, 32'h104, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t2_imm", out_imm, 32'hFFFFFFFC);
    chk("t2_fmt", out_fmt, 6'b100000);

    // illegal encodings and sub
    step(1'b1, 32'h00000000, 32'h200, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_zero", {out_invalid, out_fmt, out_imm, out_we_rd}, {1'b1, 6'd0, 32'd0, 1'b0});
    step(1'b1, 32'h0000007F, 32'h204, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_7f", {out_invalid, out_fmt, out_imm, out_we_rd}, {1'b1, 6'd0, 32'd0, 1'b0});
    step(1'b1, 32'h40000033, 32'h208, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_sub", {out_invalid, out_fmt}, {1'b0, 6'b000001});
    step(1'b1, 32'h80000033, 32'h20C, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t5_bad_f7", out_invalid, 1'b1);

    // backpressure: third instruction waits until the skid drains
    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b0);
    chk("t3_stall", in_ready, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b1, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with both entries full and a same-cycle offer
    step(1'b1, 32'h00400213, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h408, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ready", in_ready, 1'b1);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // reset mid-stream
    step(1'b1, 32'h00700393, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 32'h504, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset("t6");
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
      pc = pc + 4;
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // XLEN=64, no skid: jal sign extension and OP-32 legality
    @(negedge clk);
    in_valid64 = 1'b1; in_inst64 = 32'hFFDFF0EF; in_pc64 = 64'h1_0000_0010; out_ready64 = 1'b0;
    #1 chk("x64_ready0", in_ready64, 1'b1);
    @(negedge clk);
    in_valid64 = 1'b0;
    #1;
    chk("x64_valid", out_valid64, 1'b1);
    chk("x64_jal_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("x64_jal_fmt", out_fmt64, 6'b100000);
    chk("x64_pc", out_pc64, 64'h1_0000_0010);
    chk("x64_stall_ready", in_ready64, 1'b0);
    out_ready64 = 1'b1;
    #1 chk("x64_pass_ready", in_ready64, 1'b1);
    @(negedge clk);
    in_valid64 = 1'b1; in_inst64 = 32'h002080BB; in_pc64 = 64'h1_0000_0014;
    e64 = model(32'h002080BB, 64'h1_0000_0014, 1'b1);
    @(negedge clk);
    in_valid64 = 1'b0;
    #1;
    chk("x64_addw_inv", out_invalid64, e64.inv);
    chk("x64_addw_fmt", out_fmt64, e64.fmt);
    chk("x64_addw_flags", {out_use_rs164, out_use_rs264, out_we_rd64}, {e64.u1, e64.u2, e64.we});
    chk("x64_addw_pc", out_pc64, e64.pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
